// File: rtl/fpu_div_iterative.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa divide, one quotient bit per cycle.
// Rounding mode selected by FPU_DIV_ROUND_NEAREST_EN (defined: round-to-nearest-even, undefined: truncate).
module fpu_div_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int QBITS      = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  input  logic                  exc_sel,
  input  logic [DATA_WIDTH-1:0] exc_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int RW   = MANT_WIDTH + 3;
  localparam int EW   = EXP_WIDTH + 2;
  localparam int CW   = $clog2(QBITS);
  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EMAX = (1 << EXP_WIDTH) - 1;

  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(EMAX);
  localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                 state;
  logic                   sign;
  logic signed [EW-1:0]   exp_q;
  logic [RW-1:0]          rem;
  logic [RW-1:0]          dvsr;
  logic [QBITS-1:0]       q;
  logic [CW-1:0]          counter;

  logic                   s1, s2;
  logic [EXP_WIDTH-1:0]   e1, e2;
  logic [MANT_WIDTH-1:0]  m1, m2;
  logic signed [EW-1:0]   exp_start;
  logic [RW-1:0]          rem_diff;
  logic                   trial_ge;

  assign s1 = float_num1[DATA_WIDTH-1];
  assign s2 = float_num2[DATA_WIDTH-1];
  assign e1 = float_num1[DATA_WIDTH-2 -: EXP_WIDTH];
  assign e2 = float_num2[DATA_WIDTH-2 -: EXP_WIDTH];
  assign m1 = float_num1[MANT_WIDTH-1:0];
  assign m2 = float_num2[MANT_WIDTH-1:0];

  assign exp_start = signed'({2'b00, e1}) - signed'({2'b00, e2}) + EXP_BIAS;

  assign rem_diff = rem - dvsr;
  assign trial_ge = (rem >= dvsr);

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state == DIVIDE) || (state == NORM);

  // Normalisation, rounding and packing of the finished quotient.
  logic [MANT_WIDTH-1:0]  frac_t;
  logic                   guard, sticky, round_up;
  logic signed [EW-1:0]   exp_t, exp_fin;
  logic [MANT_WIDTH:0]    frac_sum;
  logic [MANT_WIDTH-1:0]  frac_fin;
  logic [DATA_WIDTH-1:0]  packed_res;

  always_comb begin
    frac_t = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    exp_t  = exp_q;
    if (q[QBITS-1]) begin
      frac_t = q[QBITS-2:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
    end else begin
      frac_t = q[QBITS-3:1];
      guard  = q[0];
      sticky = |rem;
      exp_t  = exp_q - EXP_ONE;
    end
  end

`ifdef FPU_DIV_ROUND_NEAREST_EN
  assign round_up = guard && (sticky || frac_t[0]);
`else
  logic round_unused;
  assign round_unused = guard ^ sticky;
  assign round_up     = 1'b0;
`endif

  always_comb begin
    frac_sum = {1'b0, frac_t} + (MANT_WIDTH + 1)'(round_up);
    frac_fin = frac_sum[MANT_WIDTH-1:0];
    exp_fin  = exp_t;
    if (frac_sum[MANT_WIDTH]) begin
      frac_fin = '0;
      exp_fin  = exp_t + EXP_ONE;
    end
    if (exp_fin >= EXP_MAX)
      packed_res = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    else if (exp_fin <= EXP_ZERO)
      packed_res = {sign, {(DATA_WIDTH-1){1'b0}}};
    else
      packed_res = {sign, exp_fin[EXP_WIDTH-1:0], frac_fin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      counter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= s1 ^ s2;
            if (!exc_sel) begin
              result    <= exc_out;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (e1 == '0) begin
              result    <= {s1 ^ s2, {(DATA_WIDTH-1){1'b0}}};
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (e2 == '0) begin
              result    <= {s1 ^ s2, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              exp_q   <= exp_start;
              rem     <= {2'b00, 1'b1, m1};
              dvsr    <= {2'b00, 1'b1, m2};
              q       <= '0;
              counter <= '0;
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          q   <= {q[QBITS-2:0], trial_ge};
          rem <= trial_ge ? {rem_diff[RW-2:0], 1'b0} : {rem[RW-2:0], 1'b0};
          if (counter == CW'(QBITS - 1)) begin
            counter <= '0;
            state   <= NORM;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        NORM: begin
          result    <= packed_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_iterative.sv
// Directed bench for fpu_div_iterative: normal divides, exception forwarding, flush, overflow/underflow,
// backpressure and mid-operation reset. Expected 1/3 result tracks FPU_DIV_ROUND_NEAREST_EN.
module tb_fpu_div_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_num1;
  logic [31:0] float_num2;
  logic        exc_sel;
  logic [31:0] exc_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int passed = 0;
  int total  = 0;

  fpu_div_iterative #(
    .DATA_WIDTH(32),
    .EXP_WIDTH (8),
    .MANT_WIDTH(23),
    .QBITS     (26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_num1(float_num1),
    .float_num2(float_num2),
    .exc_sel   (exc_sel),
    .exc_out   (exc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef FPU_DIV_ROUND_NEAREST_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, expv);
  endtask

  // Issue one operation, measure edges after the accept edge until out_valid,
  // optionally hold out_ready low for 'hold' cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sel, input logic [31:0] eo, input logic [31:0] want,
                        input int want_lat, input int hold);
    int   lat;
    logic busy_seen;
    @(negedge clk);
    float_num1 = a;
    float_num2 = b;
    exc_sel    = sel;
    exc_out    = eo;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    check({tag, ".in_ready_pre"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    float_num1 = ~a;
    float_num2 = ~b;
    exc_sel    = ~sel;
    exc_out    = ~eo;
    busy_seen  = busy;
    lat        = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      busy_seen = busy_seen | busy;
    end
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(want_lat));
    check({tag, ".result"}, result, want);
    check({tag, ".busy_seen"}, {31'b0, busy_seen}, {31'b0, (want_lat == 27)});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".hold_result"}, result, want);
      check({tag, ".hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".released_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".released_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    float_num1 = '0;
    float_num2 = '0;
    exc_sel    = 1'b0;
    exc_out    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", {31'b0, out_valid}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.in_ready_after", {31'b0, in_ready}, 32'd1);

    run_op("six_by_two",   32'h40C00000, 32'h40000000, 1'b1, 32'h0, 32'h40400000, 27, 0);
    run_op("neg_six",      32'hC0C00000, 32'h40000000, 1'b1, 32'h0, 32'hC0400000, 27, 0);
    run_op("exc_nan",      32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 32'h7FC00000, 0, 0);
    run_op("one_third",    32'h3F800000, 32'h40400000, 1'b1, 32'h0, THIRD, 27, 0);
    run_op("overflow",     32'h7F000000, 32'h00800000, 1'b1, 32'h0, 32'h7F800000, 27, 0);
    run_op("underflow",    32'h00800000, 32'h7F000000, 1'b1, 32'h0, 32'h00000000, 27, 0);
    run_op("pi_by_one",    32'h40490FDB, 32'h3F800000, 1'b1, 32'h0, 32'h40490FDB, 27, 0);
    run_op("flush_num",    32'h80400000, 32'h40000000, 1'b1, 32'h0, 32'h80000000, 0, 0);
    run_op("flush_den",    32'h40000000, 32'h80000001, 1'b1, 32'h0, 32'hFF800000, 0, 0);
    run_op("backpressure", 32'h40C00000, 32'h40000000, 1'b1, 32'h0, 32'h40400000, 27, 5);
    run_op("back_to_back", 32'h3F800000, 32'h3F800000, 1'b1, 32'h0, 32'h3F800000, 27, 0);

    // Abort a divide in progress with a single-edge reset.
    @(negedge clk);
    float_num1 = 32'h3F800000;
    float_num2 = 32'h40400000;
    exc_sel    = 1'b1;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort.out_valid", {31'b0, out_valid}, 32'd0);
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort.in_ready_high", {31'b0, in_ready}, 32'd1);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 1'b1, 32'h0, 32'h40400000, 27, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
